hazard_stall_ctrl: RTL

- Parametrised successor to the ID-stage hazard sense unit of the 5-stage MIPS pipeline.
- Detects three stall causes and drives the pipeline-control signals, as active-high enables.
  - Load-use.
  - Branch operands resolved in ID.
  - Reads of an internally tracked multi-cycle mult/div unit while that unit is busy.
- Sits beside the IF/ID and ID/EX registers.
- Owns the mult/div busy counter, the block's only sequential state, plus an optional stall counter.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/md_busy_tracker.sv | 40 ++++
 rtl/hazard_stall_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the ID-stage hazard/stall controller.
// The mult/div latency defaults are also used by the mult/div datapath, so the two stay consistent.
package hazard_pkg;
  localparam int REG_AW_DEF  = 5;
  localparam int ZERO_REG    = 0;
  localparam int MUL_CYC_DEF = 5;
  localparam int DIV_CYC_DEF = 10;
  localparam int CNT_W_DEF   = 4;

  // Stall-cause vector {lu, br, md}, kept together for debug visibility.
  typedef struct packed {
    logic lu;
    logic br;
    logic md;
  } stall_cause_t;
endpackage

// File: rtl/md_busy_tracker.sv
// Busy counter for the multi-cycle mult/div unit. It is reloaded when a mult/div leaves EX
// and counts down to zero; md_busy is high while the count is nonzero.
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MUL_CYC = MUL_CYC_DEF,
  parameter int DIV_CYC = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_e,
  input  logic md_is_div_e,
  output logic md_busy
);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYC);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYC);

  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  // A new start always reloads, even mid-count; the ID-stage md stall keeps that out of legal flow.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start_e) begin
      md_cnt_d = md_is_div_e ? DIV_LD : MUL_LD;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy = (md_cnt_q != '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard detection: load-use, ID-resolved branch operands and mult/div-busy stalls.
// Enables are active-high. Define HSC_STALL_CNT_EN to add the saturating stall_count output.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MUL_CYC     = MUL_CYC_DEF,
  parameter int DIV_CYC     = DIV_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int STALL_CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              use_rs_d,
  input  logic              use_rt_d,
  input  logic              branch_d,
  input  logic              md_use_d,
  input  logic [REG_AW-1:0] dst_e,
  input  logic              regwrite_e,
  input  logic              memread_e,
  input  logic [REG_AW-1:0] dst_m,
  input  logic              memread_m,
  input  logic              md_start_e,
  input  logic              md_is_div_e,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_flush,
  output logic              md_busy
`ifdef HSC_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_count
`endif
);
  // Register 0 is hard-wired zero, so a "write" to it never creates a dependency.
  function automatic logic hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] d);
    return (a == d) && (d != REG_AW'(ZERO_REG));
  endfunction

  function automatic logic rd_hit(input logic [REG_AW-1:0] d);
    return (use_rs_d && hit(rs_d, d)) || (use_rt_d && hit(rt_d, d));
  endfunction

  stall_cause_t cause;
  logic         stall;

  always_comb begin
    cause.lu = memread_e && rd_hit(dst_e);
    cause.br = branch_d && ((regwrite_e && rd_hit(dst_e)) || (memread_m && rd_hit(dst_m)));
    cause.md = md_use_d && (md_busy || md_start_e);
    stall    = |cause;
  end

  assign pc_en      = !stall;
  assign ifid_en    = !stall;
  assign idex_flush = stall;

  md_busy_tracker #(
    .CNT_W  (CNT_W),
    .MUL_CYC(MUL_CYC),
    .DIV_CYC(DIV_CYC)
  ) u_md_busy (
    .clk        (clk),
    .reset      (reset),
    .md_start_e (md_start_e),
    .md_is_div_e(md_is_div_e),
    .md_busy    (md_busy)
  );

`ifdef HSC_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif
endmodule
